// File: rtl/pipeline_register.sv
// PLAR pipeline register: WIDTH-bit holding register with an active-low load strobe.
// Captures di on a rising edge when plar is low; reset has priority over load.
module pipeline_register #(
   parameter int unsigned         WIDTH       = 4,
   parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] di,
   input  logic             plar,
   output logic [WIDTH-1:0] q
);

   // q carries the registered data out ("do" is a reserved word).
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VALUE;
      end else if (!plar) begin
         q <= di;
      end
   end

endmodule

// File: tb/tb_pipeline_register.sv
// Self-checking bench for pipeline_register: directed plan plus randomized run
// against a behavioural model, on a default 4-bit and an 8-bit non-zero-reset instance.
module tb_pipeline_register;

   localparam int unsigned W8 = 8;
   localparam logic [W8-1:0] RV8 = 8'hA5;

   logic          clk;
   logic          rst;
   logic          plar;
   logic [3:0]    di;
   logic [3:0]    q;
   logic [W8-1:0] di8;
   logic [W8-1:0] q8;

   int n_pass;
   int n_total;

   // Behavioural expectations for each instance
   logic [3:0]    model;
   logic [W8-1:0] model8;

   pipeline_register dut (
      .clk  (clk),
      .rst  (rst),
      .di   (di),
      .plar (plar),
      .q    (q)
   );

   pipeline_register #(.WIDTH(W8), .RESET_VALUE(RV8)) dut8 (
      .clk  (clk),
      .rst  (rst),
      .di   (di8),
      .plar (plar),
      .q    (q8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, applying the register's rules to the model, then settle.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model  = 4'h0;
         model8 = RV8;
      end else if (plar == 1'b0) begin
         model  = di;
         model8 = di8;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; plar = 1'b0; di = 4'b1111; di8 = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_total++;
         if (q !== 4'b0000) $display("FAIL reset_edge%0d: q=%h expected 0", i, q);
         else n_pass++;
         n_total++;
         if (q8 !== RV8) $display("FAIL reset8_edge%0d: q8=%h expected %h", i, q8, RV8);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      rst = 1'b0; plar = 1'b1; di = 4'b1010;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_total++;
         if (q !== 4'b0000) $display("FAIL hold_edge%0d: q=%h expected 0", i, q);
         else n_pass++;
      end
   endtask

   task automatic test_load();
      plar = 1'b0; di = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_total++;
         if (q !== 4'b1111) $display("FAIL load_edge%0d: q=%h expected f", i, q);
         else n_pass++;
      end
   endtask

   task automatic test_hold_after_load();
      plar = 1'b1; di = 4'b0101;
      tick();
      n_total++;
      if (q !== 4'b1111) $display("FAIL hold_after_load: q=%h expected f", q);
      else n_pass++;
      plar = 1'b0; di = 4'b0000;
      tick();
      n_total++;
      if (q !== 4'b0000) $display("FAIL load_zero: q=%h expected 0", q);
      else n_pass++;
      plar = 1'b1; di = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_total++;
         if (q !== 4'b0000) $display("FAIL hold_zero_edge%0d: q=%h expected 0", i, q);
         else n_pass++;
      end
   endtask

   task automatic test_streaming();
      logic [3:0] seq [3];
      logic [3:0] pending [$];
      seq[0] = 4'h3; seq[1] = 4'h9; seq[2] = 4'hC;
      plar = 1'b0;
      for (int i = 0; i < 3; i++) begin
         di = seq[i];
         pending.push_back(seq[i]);
         tick();
         n_total++;
         if (q !== pending[0]) $display("FAIL stream_%0d: q=%h expected %h", i, q, pending[0]);
         else n_pass++;
         void'(pending.pop_front());
         // Glitch di and plar between edges; q must not move.
         for (int g = 0; g < 3; g++) begin
            di = 4'($urandom);
            plar = ~plar;
            #1;
            n_total++;
            if (q !== seq[i]) $display("FAIL glitch_%0d_%0d: q=%h expected %h", i, g, q, seq[i]);
            else n_pass++;
         end
         plar = 1'b0;
      end
   endtask

   task automatic test_reset_priority();
      n_total++;
      if (q !== 4'hC) $display("FAIL prio_pre: q=%h expected c", q);
      else n_pass++;
      rst = 1'b1; plar = 1'b0; di = 4'h7;
      tick();
      n_total++;
      if (q !== 4'h0) $display("FAIL prio_reset: q=%h expected 0", q);
      else n_pass++;
      rst = 1'b0;
      tick();
      n_total++;
      if (q !== 4'h7) $display("FAIL prio_resume: q=%h expected 7", q);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rst  = ($urandom_range(0, 19) == 0);
         plar = 1'($urandom);
         di   = 4'($urandom);
         di8  = 8'($urandom);
         tick();
         n_total++;
         if (q !== model) $display("FAIL rand_%0d: q=%h expected %h", i, q, model);
         else n_pass++;
         n_total++;
         if (q8 !== model8) $display("FAIL rand8_%0d: q8=%h expected %h", i, q8, model8);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      model = 'x; model8 = 'x;
      rst = 1'b1; plar = 1'b0; di = 4'b1111; di8 = 8'hFF;
      test_reset();
      test_hold();
      test_load();
      test_hold_after_load();
      test_streaming();
      test_reset_priority();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
